// File: rtl/pipelined_signed_shift_divide.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pipelined_signed_shift_divide
// Purpose : log2(N)-stage barrel right shifter (ASR / DIV / LSR / ROR) with
//           valid/ready handshake and global-stall backpressure.
// Rev     : 1.0
// ---------------------------------------------------------------------------
module pipelined_signed_shift_divide #(
  parameter int N = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arg_vld,
  output logic          arg_rdy,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  input  logic [1:0]    mode,
  output logic          res_vld,
  input  logic          res_rdy,
  output logic [N-1:0]  res
);

  localparam logic [1:0]   MODE_DIV = 2'b01;
  localparam logic [1:0]   MODE_LSR = 2'b10;
  localparam logic [1:0]   MODE_ROR = 2'b11;
  localparam int           SBITS    = (SW * (SW + 1)) / 2;
  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

  // Stage k carries only the shift-amount bits it still needs (s[SW-1:k]),
  // packed triangularly into one flat vector.
  logic [SW:0]           vld, nxt_vld;
  logic [SW:0][N-1:0]    data, nxt_data;
  logic [SW-1:0][1:0]    md, nxt_md;
  logic [SBITS-1:0]      spipe, nxt_s;
  logic [N-1:0]          bias;
  logic                  stall;

  assign stall   = vld[SW] && !res_rdy;
  assign arg_rdy = !stall;
  assign res_vld = vld[SW];
  assign res     = data[SW];

  // Negative DIV operands get 2**s-1 added so the floor shift rounds toward 0.
  assign bias          = (mode == MODE_DIV && a[N-1]) ? ((ONE << shamt) - ONE) : '0;
  assign nxt_vld[0]    = arg_vld;
  assign nxt_data[0]   = a + bias;
  assign nxt_md[0]     = mode;
  assign nxt_s[SW-1:0] = shamt;

  for (genvar k = 1; k <= SW; k++) begin : g_stage
    localparam int SH = 1 << (k - 1);
    localparam int PO = (k - 1) * SW - ((k - 1) * (k - 2)) / 2;
    logic [N-1:0] d;
    logic [N-1:0] shifted;
    logic         fill;

    assign d           = data[k-1];
    assign fill        = (md[k-1] == MODE_LSR) ? 1'b0 : d[N-1];
    assign shifted     = (md[k-1] == MODE_ROR) ? {d[SH-1:0], d[N-1:SH]}
                                               : {{SH{fill}}, d[N-1:SH]};
    assign nxt_data[k] = spipe[PO] ? shifted : d;
    assign nxt_vld[k]  = vld[k-1];

    if (k < SW) begin : g_carry
      localparam int PN = k * SW - (k * (k - 1)) / 2;
      assign nxt_s[PN +: SW-k] = spipe[PO+1 +: SW-k];
      assign nxt_md[k]         = md[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= '0;
      data  <= '0;
      md    <= '0;
      spipe <= '0;
    end else if (!stall) begin
      vld   <= nxt_vld;
      data  <= nxt_data;
      md    <= nxt_md;
      spipe <= nxt_s;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_signed_shift_divide.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_pipelined_signed_shift_divide
// Purpose : directed and randomised self-checking bench for the shifter.
// Rev     : 1.0
// ---------------------------------------------------------------------------
module tb_pipelined_signed_shift_divide;
  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          arg_vld;
  logic          arg_rdy;
  logic [N-1:0]  a;
  logic [SW-1:0] shamt;
  logic [1:0]    mode;
  logic          res_vld;
  logic          res_rdy;
  logic [N-1:0]  res;
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  pipelined_signed_shift_divide #(.N(N)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy),
    .a(a), .shamt(shamt), .mode(mode),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res)
  );

  function automatic logic [7:0] model(input logic [7:0] x, input logic [2:0] s,
                                       input logic [1:0] m);
    logic [15:0] dbl;
    int          xi;
    int          q;
    xi  = $signed(x);
    q   = xi / (1 << s);
    dbl = {x, x} >> s;
    case (m)
      2'b00:   model = $signed(x) >>> s;
      2'b01:   model = q[7:0];
      2'b10:   model = x >> s;
      default: model = dbl[7:0];
    endcase
  endfunction

  // Drives one transaction into an empty pipe and waits (bounded) for its result.
  task automatic run_one(input logic [7:0] ia, input logic [2:0] is, input logic [1:0] im,
                         output logic [7:0] r, output int lat);
    @(negedge clk);
    a = ia; shamt = is; mode = im; arg_vld = 1'b1; res_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arg_vld = 1'b0;
    lat = 1;
    while (!res_vld && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = res;
    if (!res_vld) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; arg_vld = 1'b0; res_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (res_vld !== 1'b0) begin fails++; $display("FAIL reset_res_vld got=%b want=0", res_vld); end
    tests++;
    if (res !== 8'h00) begin fails++; $display("FAIL reset_res got=%h want=00", res); end
    tests++;
    if (arg_rdy !== 1'b1) begin fails++; $display("FAIL reset_arg_rdy got=%b want=1", arg_rdy); end
  endtask

  task automatic test_asr();
    logic [7:0] r; int lat;
    run_one(8'h96, 3'd3, 2'b00, r, lat);
    tests++;
    if (r !== 8'hF2) begin fails++; $display("FAIL asr_96_s3 got=%h want=f2", r); end
    tests++;
    if (lat != 4) begin fails++; $display("FAIL asr_latency got=%0d want=4", lat); end
    run_one(8'h80, 3'd7, 2'b00, r, lat);
    tests++;
    if (r !== 8'hFF) begin fails++; $display("FAIL asr_80_s7 got=%h want=ff", r); end
  endtask

  task automatic test_div();
    logic [7:0] va [6] = '{8'h96, 8'hF8, 8'h6A, 8'hFF, 8'h80, 8'h81};
    logic [2:0] vs [6] = '{3'd3,  3'd3,  3'd3,  3'd5,  3'd7,  3'd7};
    logic [7:0] ve [6] = '{8'hF3, 8'hFF, 8'h0D, 8'h00, 8'hFF, 8'h00};
    logic [7:0] r; int lat;
    for (int i = 0; i < 6; i++) begin
      run_one(va[i], vs[i], 2'b01, r, lat);
      tests++;
      if (r !== ve[i] || lat != 4) begin
        fails++;
        $display("FAIL div_%0d a=%h s=%0d got=%h lat=%0d want=%h lat=4", i, va[i], vs[i], r, lat, ve[i]);
      end
    end
  endtask

  task automatic test_lsr_ror();
    logic [7:0] r; int lat;
    run_one(8'h96, 3'd3, 2'b10, r, lat);
    tests++;
    if (r !== 8'h12) begin fails++; $display("FAIL lsr_96_s3 got=%h want=12", r); end
    run_one(8'h96, 3'd3, 2'b11, r, lat);
    tests++;
    if (r !== 8'hD2) begin fails++; $display("FAIL ror_96_s3 got=%h want=d2", r); end
    run_one(8'hF1, 3'd1, 2'b11, r, lat);
    tests++;
    if (r !== 8'hF8) begin fails++; $display("FAIL ror_f1_s1 got=%h want=f8", r); end
  endtask

  task automatic test_shift_zero();
    logic [7:0] r; int lat;
    for (int m = 0; m < 4; m++) begin
      run_one(8'h96, 3'd0, 2'(m), r, lat);
      tests++;
      if (r !== 8'h96) begin fails++; $display("FAIL s0_mode%0d got=%h want=96", m, r); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [8] = '{8'h80, 8'h80, 8'h7F, 8'hF1, 8'hF1, 8'h81, 8'h01, 8'hAA};
    logic [2:0] vs [8] = '{3'd7, 3'd1, 3'd2, 3'd4, 3'd1, 3'd7, 3'd0, 3'd5};
    logic [1:0] vm [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b01, 2'b11};
    logic [7:0] ve [8] = '{8'hFF, 8'hC0, 8'h1F, 8'h0F, 8'hF8, 8'h00, 8'h01, 8'h55};
    int         sent = 0;
    int         got = 0;
    int         stalls = 0;
    logic       was_stall = 1'b0;
    logic [7:0] held = 8'h00;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      res_rdy = !(c >= 5 && c <= 7);
      arg_vld = (sent < 8);
      if (sent < 8) begin a = va[sent]; shamt = vs[sent]; mode = vm[sent]; end
      #1;
      tests++;
      if (arg_rdy !== ~(res_vld & ~res_rdy)) begin
        fails++;
        $display("FAIL b2b_arg_rdy c=%0d got=%b want=%b", c, arg_rdy, ~(res_vld & ~res_rdy));
      end
      if (was_stall) begin
        tests++;
        if (res !== held) begin fails++; $display("FAIL b2b_hold c=%0d got=%h want=%h", c, res, held); end
      end
      if (res_vld && res_rdy) begin
        tests++;
        if (res !== ve[got]) begin fails++; $display("FAIL b2b_res%0d got=%h want=%h", got, res, ve[got]); end
        got++;
      end
      if (res_vld && !res_rdy) stalls++;
      was_stall = res_vld && !res_rdy;
      held      = res;
      if (arg_vld && arg_rdy) sent++;
    end
    arg_vld = 1'b0; res_rdy = 1'b1;
    tests++;
    if (got != 8 || stalls != 3) begin
      fails++;
      $display("FAIL b2b_counts got=%0d stalls=%0d want=8 stalls=3", got, stalls);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    res_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      arg_vld = 1'b1; a = 8'h10 + 8'(i); shamt = 3'd1; mode = 2'b10;
    end
    @(negedge clk);
    rst = 1'b1; arg_vld = 1'b1; a = 8'h77; shamt = 3'd0; mode = 2'b00;
    @(negedge clk);
    rst = 1'b0; arg_vld = 1'b0;
    tests++;
    if (res_vld !== 1'b0 || res !== 8'h00) begin
      fails++;
      $display("FAIL midrst_after got vld=%b res=%h want vld=0 res=00", res_vld, res);
    end
    repeat (10) begin
      @(negedge clk);
      if (res_vld) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL midrst_stale got=%0d want=0", seen); end
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic [7:0] exp;
    int         acc = 0;
    int         prod = 0;
    logic       pend = 1'b0;
    arg_vld = 1'b0; res_rdy = 1'b1;
    for (int c = 0; c < 10020; c++) begin
      @(negedge clk);
      if (c < 10000) begin
        if (!pend) begin
          arg_vld = ($urandom_range(0, 3) != 0);
          a = 8'($urandom); shamt = 3'($urandom); mode = 2'($urandom);
        end
        res_rdy = ($urandom_range(0, 3) != 0);
      end else begin
        arg_vld = 1'b0; res_rdy = 1'b1;
      end
      #1;
      if (arg_vld && arg_rdy) begin q.push_back(model(a, shamt, mode)); acc++; end
      if (res_vld && res_rdy) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL rand_extra c=%0d got=%h want=none", c, res);
        end else begin
          exp = q.pop_front();
          if (res !== exp) begin fails++; $display("FAIL rand_res c=%0d got=%h want=%h", c, res, exp); end
        end
        prod++;
      end
      pend = arg_vld && !arg_rdy;
    end
    tests++;
    if (acc != prod || q.size() != 0) begin
      fails++;
      $display("FAIL rand_count got=%0d want=%0d", prod, acc);
    end
  endtask

  initial begin
    rst = 1'b1; arg_vld = 1'b0; res_rdy = 1'b1;
    a = '0; shamt = '0; mode = '0;
    test_reset();
    test_asr();
    test_div();
    test_lsr_ror();
    test_shift_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
